// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment scan display.
//   SEG_PAT  : active-low patterns {g,f,e,d,c,b,a} for BCD 0..9
//   SEG_DASH : pattern shown for a stored value above 9 (segment g only)
//   SEG_OFF  : all segments dark
//   state_t  : scan FSM state (blanking gap / digit lit)
package seg7_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [6:0] SEG_PAT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-low seven-segment decoder.
//   bcd   in  4  digit value; values above 9 decode to a dash
//   blank in  1  force all segments dark (leading-zero blanking)
//   seg   out 7  segments {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_OFF;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_PAT[0];
        4'd1:    seg = SEG_PAT[1];
        4'd2:    seg = SEG_PAT[2];
        4'd3:    seg = SEG_PAT[3];
        4'd4:    seg = SEG_PAT[4];
        4'd5:    seg = SEG_PAT[5];
        4'd6:    seg = SEG_PAT[6];
        4'd7:    seg = SEG_PAT[7];
        4'd8:    seg = SEG_PAT[8];
        4'd9:    seg = SEG_PAT[9];
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: latches BCD digits into a register bank and time-multiplexes
// NUM_DIGITS common-anode seven-segment digits, with a blanking gap between
// digits to suppress ghosting.
//   clk       in   1          rising-edge clock
//   rst       in   1          asynchronous reset, active-high
//   din       in   4          BCD digit value
//   din_vld   in   1          write strobe: din -> digit[din_sel]
//   din_sel   in   SEL_W      target digit index, 0 = least significant
//   lzb_en    in   1          blank leading zero digits (never digit 0)
//   seg       out  7          segments {g,f,e,d,c,b,a}, active-low, registered
//   an        out  NUM_DIGITS anode enables, active-low one-hot, registered
//   err       out  1          sticky: bad value (>9) or bad din_sel written
//   dbg_state out  state_t    current scan FSM state
// Handshake: din_vld is a single-cycle strobe with no backpressure; every edge
// where din_vld=1 is a write, and the bank always accepts it.
// LZB_EN=0 removes leading-zero blanking regardless of the lzb_en port.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter bit LZB_EN       = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    din,
  input  logic                          din_vld,
  input  logic [$clog2(NUM_DIGITS)-1:0] din_sel,
  input  logic                          lzb_en,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          err,
  output state_t                        dbg_state
);

  localparam int SEL_W   = $clog2(NUM_DIGITS);
  localparam int DIV_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int DIV_W   = $clog2(DIV_MAX);

  state_t                  state, state_nxt;
  logic [DIV_W-1:0]        div, div_nxt;
  logic [SEL_W-1:0]        idx, idx_nxt;
  logic [3:0]              digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lzb_vec;
  logic                    zero_above;
  logic                    lzb_act;
  logic                    sel_ok;
  logic                    wr_ok;
  logic                    wr_bad;
  logic [6:0]              dec_seg;

  assign dbg_state = state;
  assign lzb_act   = lzb_en & LZB_EN;
  assign sel_ok    = (int'(din_sel) < NUM_DIGITS);
  assign wr_ok     = din_vld & sel_ok;
  assign wr_bad    = din_vld & ((din > 4'd9) | ~sel_ok);

  // Digit bank: out-of-range selects are dropped, values >9 are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= 4'd0;
    end else if (wr_ok) begin
      digit[din_sel] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err <= 1'b0;
    else if (wr_bad) err <= 1'b1;
  end

  // Scan FSM state, dwell counter and digit index.
  // idx starts at the top digit so the first BLANK->ON step lands on digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_BLANK;
      div   <= '0;
      idx   <= SEL_W'(NUM_DIGITS - 1);
    end else begin
      state <= state_nxt;
      div   <= div_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div + 1'b1;
    idx_nxt   = idx;
    case (state)
      ST_BLANK: begin
        if (div == DIV_W'(BLANK_CYCLES - 1)) begin
          div_nxt   = '0;
          state_nxt = ST_ON;
          idx_nxt   = (idx == SEL_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
      end
      ST_ON: begin
        if (div == DIV_W'(REFRESH_DIV - 1)) begin
          div_nxt   = '0;
          state_nxt = ST_BLANK;
        end
      end
      default: begin
        div_nxt   = '0;
        state_nxt = ST_BLANK;
      end
    endcase
  end

  // A digit above 0 is blanked when it and every more significant digit are 0.
  always_comb begin
    lzb_vec    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above & (digit[i] == 4'd0);
      lzb_vec[i] = zero_above & lzb_act;
    end
  end

  bcd_to_seg7 u_dec (
    .bcd   (digit[idx]),
    .blank (lzb_vec[idx]),
    .seg   (dec_seg)
  );

  // Outputs are sampled from the registered state, so a write to the lit digit
  // simply shows on the next edge without disturbing the anode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_OFF;
    end else if (state == ST_ON) begin
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= dec_seg;
    end else begin
      an  <= '1;
      seg <= SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1
// (scan period 20 cycles) plus a NUM_DIGITS=3 instance for the bad-select case.
module tb_seg7_scan_driver;
  import seg7_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic       rst = 1'b1;
  logic [3:0] din = 4'd0;
  logic       din_vld = 1'b0;
  logic [1:0] din_sel = 2'd0;
  logic       lzb_en = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       err;
  state_t     dbg_state;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .LZB_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_sel(din_sel),
    .lzb_en(lzb_en), .seg(seg), .an(an), .err(err), .dbg_state(dbg_state)
  );

  // Three-digit instance
  logic       rst3 = 1'b1;
  logic [3:0] din3 = 4'd0;
  logic       din3_vld = 1'b0;
  logic [1:0] din3_sel = 2'd0;
  logic       lzb3 = 1'b0;
  logic [6:0] seg3;
  logic [2:0] an3;
  logic       err3;
  state_t     dbg3;

  seg7_scan_driver #(
    .NUM_DIGITS(3), .REFRESH_DIV(4), .BLANK_CYCLES(1), .LZB_EN(1'b1)
  ) dut3 (
    .clk(clk), .rst(rst3), .din(din3), .din_vld(din3_vld), .din_sel(din3_sel),
    .lzb_en(lzb3), .seg(seg3), .an(an3), .err(err3), .dbg_state(dbg3)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [3:0] mdl [4];
  logic       merr = 1'b0;
  int         k;

  localparam logic [6:0] PAT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] exp_pat(input logic [3:0] v);
    logic [6:0] r;
    r = (v > 4'd9) ? 7'h3F : PAT[v];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock: expected an/seg from the scan position and the digit model as it
  // stood before this edge; the write captured at this edge then updates the model.
  task automatic tick();
    logic [3:0] ean;
    logic [6:0] eseg;
    int         pos;
    int         d;
    logic       z;
    @(posedge clk);
    cyc++;
    pos = (cyc - 1) % 5;
    d   = ((cyc - 1) / 5) % 4;
    if (pos == 0) begin
      ean  = 4'hF;
      eseg = 7'h7F;
    end else begin
      ean = ~(4'b0001 << d);
      z   = 1'b1;
      for (int i = 3; i >= d; i--) z = z & (mdl[i] == 4'd0);
      eseg = (lzb_en && d > 0 && z) ? 7'h7F : exp_pat(mdl[d]);
    end
    if (din_vld) begin
      mdl[din_sel] = din;
      if (din > 4'd9) merr = 1'b1;
    end
    #1;
    chk("an", {3'b000, an}, {3'b000, ean});
    chk("seg", seg, eseg);
    chk("err", {6'd0, err}, {6'd0, merr});
    din_vld = 1'b0;
  endtask

  task automatic wr(input logic [1:0] s, input logic [3:0] v);
    din_vld = 1'b1;
    din_sel = s;
    din     = v;
  endtask

  // Assert reset away from the edge and confirm outputs drop without a clock.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    din_vld = 1'b0;
    #1;
    chk("rst_an", {3'b000, an}, 7'h0F);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_err", {6'd0, err}, 7'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 4; i++) mdl[i] = 4'd0;
    merr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mdl[i] = 4'd0;

    // Reset timing and load of 1,2,3,4 without blanking
    do_reset();
    lzb_en = 1'b0;
    wr(2'd0, 4'd1);
    for (int c = 1; c <= 23; c++) begin
      tick();
      case (cyc)
        1:  chk("t1_first_blank", {3'b000, an}, 7'h0F);
        2:  begin chk("t1_d0_an", {3'b000, an}, 7'h0E); chk("t2_d0_seg", seg, 7'h79); end
        5:  chk("t1_d0_last", {3'b000, an}, 7'h0E);
        6:  chk("t1_gap", {3'b000, an}, 7'h0F);
        7:  begin chk("t1_d1_an", {3'b000, an}, 7'h0D); chk("t2_d1_seg", seg, 7'h24); end
        12: begin chk("t2_d2_an", {3'b000, an}, 7'h0B); chk("t2_d2_seg", seg, 7'h30); end
        17: begin chk("t2_d3_an", {3'b000, an}, 7'h07); chk("t2_d3_seg", seg, 7'h19); end
        22: begin chk("t2_wrap_an", {3'b000, an}, 7'h0E); chk("t2_wrap_seg", seg, 7'h79); end
        default: ;
      endcase
      if (cyc < 4) wr(2'(cyc), 4'(cyc + 1));
    end

    // Mid-scan reset while digit 0 is lit
    do_reset();

    // Leading-zero blanking with {0,5,0,0}, then all digits zero
    lzb_en = 1'b1;
    wr(2'd0, 4'd0);
    for (int c = 1; c <= 42; c++) begin
      tick();
      case (cyc)
        7:  chk("t3_d1", seg, 7'h40);
        12: chk("t3_d2", seg, 7'h12);
        17: begin chk("t3_d3", seg, 7'h7F); chk("t3_d3_an", {3'b000, an}, 7'h07); end
        22: chk("t3_d0", seg, 7'h40);
        27: begin chk("t3z_d1", seg, 7'h7F); chk("t3z_d1_an", {3'b000, an}, 7'h0D); end
        32: chk("t3z_d2", seg, 7'h7F);
        37: chk("t3z_d3", seg, 7'h7F);
        42: chk("t3z_d0", seg, 7'h40);
        default: ;
      endcase
      case (cyc)
        1:  wr(2'd1, 4'd0);
        2:  wr(2'd2, 4'd5);
        3:  wr(2'd3, 4'd0);
        22: wr(2'd2, 4'd0);
        default: ;
      endcase
    end

    // Live update of the lit digit 0 with 0..9
    lzb_en = 1'b0;
    do_reset();
    wr(2'd0, 4'd0);
    k = 1;
    for (int c = 1; c <= 46; c++) begin
      tick();
      case (cyc)
        5:  chk("t4_v3", seg, 7'h30);
        6:  chk("t4_gap", {3'b000, an}, 7'h0F);
        25: chk("t4_v7", seg, 7'h78);
        43: chk("t4_v9", seg, 7'h10);
        45: chk("t4_v9_hold", seg, 7'h10);
        default: ;
      endcase
      if ((cyc % 20) < 4 && k < 10) begin
        wr(2'd0, 4'(k));
        k++;
      end
    end

    // Error: value >9 and sticky err
    do_reset();
    wr(2'd1, 4'hC);
    for (int c = 1; c <= 27; c++) begin
      tick();
      case (cyc)
        1:  chk("t5_err_set", {6'd0, err}, 7'h01);
        7:  chk("t5_dash", seg, 7'h3F);
        27: begin chk("t5_fix_seg", seg, 7'h12); chk("t5_err_hold", {6'd0, err}, 7'h01); end
        default: ;
      endcase
      if (cyc == 21) wr(2'd1, 4'd5);
    end
    do_reset();

    // Error: din_sel beyond NUM_DIGITS on the three-digit instance
    @(posedge clk);
    #1;
    rst3     = 1'b0;
    din3_vld = 1'b1;
    din3_sel = 2'd3;
    din3     = 4'd7;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk);
      #1;
      din3_vld = 1'b0;
      case (c)
        1:  chk("t5b_err", {6'd0, err3}, 7'h01);
        2:  begin chk("t5b_an0", {4'd0, an3}, 7'h06); chk("t5b_seg0", seg3, 7'h40); end
        7:  begin chk("t5b_an1", {4'd0, an3}, 7'h05); chk("t5b_seg1", seg3, 7'h40); end
        12: begin chk("t5b_an2", {4'd0, an3}, 7'h03); chk("t5b_seg2", seg3, 7'h40); end
        17: begin chk("t5b_wrap", {4'd0, an3}, 7'h06); chk("t5b_err_hold", {6'd0, err3}, 7'h01); end
        default: ;
      endcase
    end
    rst3 = 1'b1;
    #1;
    chk("t5b_err_clr", {6'd0, err3}, 7'h00);

    // Counter hookup on digit 0, digits 1..3 preloaded with 7,8,9
    do_reset();
    wr(2'd1, 4'd7);
    for (int c = 1; c <= 45; c++) begin
      tick();
      case (cyc)
        7:  chk("t6_d1", seg, 7'h78);
        12: chk("t6_d2", seg, 7'h00);
        17: chk("t6_d3", seg, 7'h10);
        22: chk("t6_c7", seg, 7'h78);
        23: chk("t6_c8", seg, 7'h00);
        24: chk("t6_c9", seg, 7'h10);
        25: chk("t6_wrap0", seg, 7'h40);
        27: chk("t6_d1_keep", seg, 7'h78);
        default: ;
      endcase
      if (cyc == 1)      wr(2'd2, 4'd8);
      else if (cyc == 2) wr(2'd3, 4'd9);
      else               wr(2'd0, 4'((cyc - 3) % 10));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
